// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between an instruction-fetch (IF)
// and a data load/store (DM) requester, one transaction at a time, with starvation and hang guards.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 64,
  localparam int STREAK_W  = $clog2(STREAK_MAX + 1),
  localparam int TIMER_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_valid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_valid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                err_o,
  output logic [1:0]          dbg_state_o,
  output logic [STREAK_W-1:0] dbg_streak_o
);

  // Handshake: a requester holds req plus its command until its 1-cycle gnt pulse, and
  // completion is the 1-cycle valid pulse. Toward memory, mem_req_o and the command stay
  // stable until mem_ack_i; an ack completes the command in the cycle it is seen.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [STREAK_W-1:0] streak, streak_next;
  logic [TIMER_W-1:0]  timer, timer_next;

  logic                mem_req_next;
  logic                mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_next;
  logic                if_gnt_next, dm_gnt_next;
  logic                if_valid_next, dm_valid_next;
  logic                err_next;
  logic [DATA_W-1:0]   if_rdata_next, dm_rdata_next;

  logic                if_wins;
  logic                streak_full;
  logic                timer_expired;

  assign streak_full   = (streak == STREAK_W'(STREAK_MAX));
  assign if_wins       = if_req_i && (!dm_req_i || streak_full);
  assign timer_expired = (timer == TIMER_W'(TIMEOUT));

  assign dbg_state_o  = state;
  assign dbg_streak_o = streak;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      streak      <= '0;
      timer       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_gnt_o    <= 1'b0;
      dm_gnt_o    <= 1'b0;
      if_valid_o  <= 1'b0;
      dm_valid_o  <= 1'b0;
      err_o       <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      state       <= state_next;
      streak      <= streak_next;
      timer       <= timer_next;
      mem_req_o   <= mem_req_next;
      mem_we_o    <= mem_we_next;
      mem_addr_o  <= mem_addr_next;
      mem_wdata_o <= mem_wdata_next;
      if_gnt_o    <= if_gnt_next;
      dm_gnt_o    <= dm_gnt_next;
      if_valid_o  <= if_valid_next;
      dm_valid_o  <= dm_valid_next;
      err_o       <= err_next;
      if_rdata_o  <= if_rdata_next;
      dm_rdata_o  <= dm_rdata_next;
    end
  end

  always_comb begin
    state_next     = state;
    streak_next    = streak;
    timer_next     = timer;
    mem_req_next   = mem_req_o;
    mem_we_next    = mem_we_o;
    mem_addr_next  = mem_addr_o;
    mem_wdata_next = mem_wdata_o;
    if_gnt_next    = 1'b0;
    dm_gnt_next    = 1'b0;
    if_valid_next  = 1'b0;
    dm_valid_next  = 1'b0;
    err_next       = 1'b0;
    if_rdata_next  = if_rdata_o;
    dm_rdata_next  = dm_rdata_o;

    case (state)
      IDLE: begin
        // mem_ack_i is deliberately ignored here: no command is outstanding.
        if (if_req_i || dm_req_i) begin
          mem_req_next = 1'b1;
          timer_next   = TIMER_W'(1);
          if (if_wins) begin
            state_next     = BUSY_IF;
            if_gnt_next    = 1'b1;
            mem_we_next    = 1'b0;
            mem_addr_next  = if_addr_i;
            mem_wdata_next = '0;
            streak_next    = '0;
          end else begin
            state_next     = BUSY_DM;
            dm_gnt_next    = 1'b1;
            mem_we_next    = dm_we_i;
            mem_addr_next  = dm_addr_i;
            mem_wdata_next = dm_wdata_i;
            // Only DM wins that made a fetch wait count toward forcing the fetch through.
            if (if_req_i && !streak_full) begin
              streak_next = streak + STREAK_W'(1);
            end
          end
        end
      end

      BUSY_IF, BUSY_DM: begin
        if (mem_ack_i) begin
          // A late ack on the very last timer cycle still counts as success.
          state_next   = IDLE;
          mem_req_next = 1'b0;
          timer_next   = '0;
          if (state == BUSY_IF) begin
            if_valid_next = 1'b1;
            if (!mem_we_o) if_rdata_next = mem_rdata_i;
          end else begin
            dm_valid_next = 1'b1;
            if (!mem_we_o) dm_rdata_next = mem_rdata_i;
          end
        end else if (timer_expired) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          timer_next   = '0;
          err_next     = 1'b1;
          if (state == BUSY_IF) begin
            if_valid_next = 1'b1;
            if_rdata_next = '0;
          end else begin
            dm_valid_next = 1'b1;
            dm_rdata_next = '0;
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
        timer_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a latency-programmable memory responder, directed scenarios
// plus a short random run, and a monitor that scores every completion against an expected queue.
module tb_unified_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int W      = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o, if_valid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i, dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_gnt_o, dm_valid_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              err_o;
  logic [1:0]        dbg_state_o;
  logic [2:0]        dbg_streak_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [W-1:0]      if_exp_q[$];
  logic [W-1:0]      dm_exp_q[$];
  logic [DATA_W-1:0] dm_model;

  int   ack_delay = 1;
  logic ack_en = 1'b1;
  logic idle_noise = 1'b0;
  int   busy_cnt = 0;

  unified_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(dm_gnt_o), .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o), .dbg_state_o(dbg_state_o), .dbg_streak_o(dbg_streak_o)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A00093;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: ack after ack_delay extra BUSY cycles; optional stray acks while idle.
  always @(negedge clk) begin
    if (rst_i || !mem_req_o) begin
      busy_cnt  = 0;
      mem_ack_i = idle_noise && ($urandom_range(0, 1) == 1);
    end else begin
      busy_cnt++;
      mem_ack_i = ack_en && (busy_cnt > ack_delay);
    end
    mem_rdata_i = (mem_req_o && mem_ack_i) ? rdata_for(mem_addr_o) : 32'hDEADBEEF;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_i) begin
      if (if_gnt_o || dm_gnt_o) check("gnt_onehot", if_gnt_o & dm_gnt_o, 0);
      if (if_gnt_o) begin
        check("if_cmd_ctl", {mem_req_o, mem_we_o}, 2'b10);
        check("if_cmd_addr", mem_addr_o, if_addr_i);
        check("if_cmd_wdata", mem_wdata_o, 0);
      end
      if (dm_gnt_o) begin
        check("dm_cmd_ctl", {mem_req_o, mem_we_o}, {1'b1, dm_we_i});
        check("dm_cmd_addr", mem_addr_o, dm_addr_i);
        check("dm_cmd_wdata", mem_wdata_o, dm_wdata_i);
      end
      if (if_valid_o || dm_valid_o) begin
        check("valid_onehot", if_valid_o & dm_valid_o, 0);
        check("req_dropped", mem_req_o, 0);
      end
      if (err_o && !if_valid_o && !dm_valid_o) check("err_without_valid", 1, 0);
      if (if_valid_o) begin
        if (if_exp_q.size() == 0) check("if_unexpected_valid", 1, 0);
        else check("if_result", {err_o, if_rdata_o}, if_exp_q.pop_front());
      end
      if (dm_valid_o) begin
        if (dm_exp_q.size() == 0) check("dm_unexpected_valid", 1, 0);
        else check("dm_result", {err_o, dm_rdata_o}, dm_exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic do_if(input logic [31:0] addr, input logic exp_err, input int exp_lat,
                       output int gnt_cyc);
    int n;
    if_addr_i = addr;
    if_req_i  = 1'b1;
    if_exp_q.push_back(exp_err ? {1'b1, 32'h0} : {1'b0, rdata_for(addr)});
    n = 0;
    do begin @(negedge clk); n++; end while (!if_gnt_o && n < 200);
    check("if_gnt_seen", if_gnt_o, 1);
    if_req_i = 1'b0;
    gnt_cyc  = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_valid_o && n < 200);
    check("if_valid_seen", if_valid_o, 1);
    check("if_latency", cyc - gnt_cyc, exp_lat);
  endtask

  task automatic do_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input int exp_lat, output int gnt_cyc);
    int n;
    dm_we_i    = we;
    dm_addr_i  = addr;
    dm_wdata_i = wdata;
    dm_req_i   = 1'b1;
    if (exp_err) dm_model = '0;
    else if (!we) dm_model = rdata_for(addr);
    dm_exp_q.push_back({exp_err, dm_model});
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_gnt_o && n < 200);
    check("dm_gnt_seen", dm_gnt_o, 1);
    dm_req_i = 1'b0;
    gnt_cyc  = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_valid_o && n < 200);
    check("dm_valid_seen", dm_valid_o, 1);
    check("dm_latency", cyc - gnt_cyc, exp_lat);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((dbg_state_o != 2'd0 || mem_req_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", (dbg_state_o == 2'd0) && !mem_req_o, 1);
    @(negedge clk);
  endtask

  initial begin
    int dc, ic, n, ngnt, first_c, last_c, kind;
    logic [5:0] pat;
    logic [31:0] a;

    rst_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h44;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40; dm_wdata_i = '0;
    dm_model = '0;

    // Reset held two cycles with both requests pending
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_pulses", {if_gnt_o, if_valid_o, dm_gnt_o, dm_valid_o, err_o}, 0);
      check("rst_mem_ctl", {mem_req_o, mem_we_o}, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_wdata", mem_wdata_o, 0);
      check("rst_rdata", {if_rdata_o, dm_rdata_o}, 0);
      check("rst_state", {dbg_state_o, dbg_streak_o}, 0);
    end
    dm_model = rdata_for(32'h40);
    dm_exp_q.push_back({1'b0, dm_model});
    if_exp_q.push_back({1'b0, rdata_for(32'h44)});
    rst_i = 1'b0;
    @(negedge clk);
    check("first_gnt_after_rst", {dm_gnt_o, if_gnt_o}, 2'b10);
    dm_req_i = 1'b0;
    n = 0;
    while (!if_gnt_o && n < 50) begin @(negedge clk); n++; end
    check("rst_if_gnt", if_gnt_o, 1);
    if_req_i = 1'b0;
    wait_idle();

    // IF read, ack three cycles after the grant cycle
    ack_delay = 3;
    do_if(32'h10, 1'b0, 4, ic);
    check("if_rdata_held", if_rdata_o, 32'h00A00093);
    wait_idle();

    // Both requesting: DM write goes first, IF follows; DM read data untouched by the write
    ack_delay = 2;
    fork
      do_dm(1'b1, 32'h20, 32'h55, 1'b0, 3, dc);
      do_if(32'h30, 1'b0, 3, ic);
    join
    check("both_dm_first", dc < ic, 1);
    check("both_if_gap", ic - dc, 4);
    check("both_dm_rdata_kept", dm_rdata_o, rdata_for(32'h40));
    wait_idle();

    // Starvation guard with single-cycle memory
    ack_delay = 0;
    dm_we_i = 1'b0; dm_addr_i = 32'h80; dm_wdata_i = '0; if_addr_i = 32'h84;
    dm_model = rdata_for(32'h80);
    for (int k = 0; k < 5; k++) dm_exp_q.push_back({1'b0, dm_model});
    if_exp_q.push_back({1'b0, rdata_for(32'h84)});
    check("streak_pre", dbg_streak_o, 0);
    dm_req_i = 1'b1; if_req_i = 1'b1;
    ngnt = 0; n = 0; pat = '0; first_c = 0; last_c = 0;
    while (ngnt < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (dm_gnt_o || if_gnt_o) begin
        pat = {pat[4:0], dm_gnt_o};
        ngnt++;
        if (ngnt == 1) first_c = cyc;
        if (ngnt == 4) check("streak_saturated", dbg_streak_o, 4);
        if (ngnt == 5) check("streak_cleared", dbg_streak_o, 0);
        last_c = cyc;
      end
    end
    dm_req_i = 1'b0; if_req_i = 1'b0;
    check("starve_pattern", pat, 6'b111101);
    check("starve_span", last_c - first_c, 10);
    wait_idle();

    // Ack on the final timer cycle still succeeds
    ack_delay = 63;
    do_dm(1'b0, 32'h90, 32'h0, 1'b0, 64, dc);
    wait_idle();

    // Timeout: never acked
    ack_en = 1'b0;
    do_dm(1'b0, 32'hA0, 32'h0, 1'b1, 64, dc);
    check("timeout_rdata", dm_rdata_o, 0);
    ack_en = 1'b1;
    wait_idle();

    // Random mix with stray idle acks
    idle_noise = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ack_delay = $urandom_range(0, 5);
      kind = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 255)) << 2;
      if (kind == 0) do_if(a, 1'b0, ack_delay + 1, ic);
      else do_dm(kind == 2, a, $urandom, 1'b0, ack_delay + 1, dc);
      wait_idle();
    end
    idle_noise = 1'b0;

    // Reset in the second BUSY cycle abandons the transaction
    ack_delay = 0;
    do_if(32'hC0, 1'b0, 1, ic);
    wait_idle();
    ack_en = 1'b0;
    dm_we_i = 1'b0; dm_addr_i = 32'hB0; if_addr_i = 32'hB4;
    dm_req_i = 1'b1; if_req_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_gnt_o && n < 50);
    check("rmb_gnt", dm_gnt_o, 1);
    check("rmb_streak_pre", dbg_streak_o, 1);
    dm_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1; if_req_i = 1'b0;
    @(negedge clk);
    check("rmb_req_dropped", mem_req_o, 0);
    check("rmb_no_pulse", {if_valid_o, dm_valid_o, err_o}, 0);
    check("rmb_state", {dbg_state_o, dbg_streak_o}, 0);
    check("rmb_rdata", {if_rdata_o, dm_rdata_o}, 0);
    rst_i = 1'b0; ack_en = 1'b1; dm_model = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rmb_quiet", {if_valid_o, dm_valid_o, err_o, mem_req_o}, 0);
    end
    ack_delay = 2;
    do_dm(1'b0, 32'hD0, 32'h0, 1'b0, 3, dc);
    wait_idle();

    check("queues_drained", if_exp_q.size() + dm_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
